npu_vec_loader: RTL and testbench

- Input-side stage directly upstream of the two-layer NPU core.
- Accepts a serial valid/ready stream of signed DATA_WIDTH elements and assembles them into an IN_N-element parallel vector.
- Presents each completed vector on vec_out with a valid/ready handshake to the core's in_vec.
- Double-buffered (fill buffer + output buffer), so one vector is streamed in while the previous one is held for the core.

---
 rtl/npu_vec_loader.sv | 132 +++++++++++++
 tb/tb_npu_vec_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/npu_vec_loader.sv
// Serial-to-parallel vector loader feeding the NPU core: double-buffered (fill + output) with valid/ready on both sides.
// Optional framing check on s_last is enabled by defining NPU_VEC_LOADER_LAST_CHECK_EN.
`ifndef N
`define N 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module npu_vec_loader #(
   parameter int IN_N       = `N,
   parameter int DATA_WIDTH = `DATA_WIDTH,
   localparam int CNT_W     = (IN_N > 1) ? $clog2(IN_N) : 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                s_valid,
   output logic                                s_ready,
   input  logic signed [DATA_WIDTH-1:0]        s_data,
   input  logic                                s_last,
   output logic signed [IN_N-1:0][DATA_WIDTH-1:0] vec_out,
   output logic                                vec_valid,
   input  logic                                vec_ready,
   output logic                                frame_err
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IN_N - 1);

   logic [CNT_W-1:0]                  idx_q, idx_d;
   logic [IN_N-1:0][DATA_WIDTH-1:0]   fill_q, fill_d;
   logic [IN_N-1:0][DATA_WIDTH-1:0]   out_q, out_d;
   logic [IN_N-1:0][DATA_WIDTH-1:0]   fill_w_s;
   logic                              vec_valid_q, vec_valid_d;
   logic                              pending_q, pending_d;
   logic                              frame_err_q, frame_err_d;
   logic                              accept_s;
   logic                              at_end_s;
   logic                              complete_s;
   logic                              slot_free_s;

   // Next-state logic: element capture, vector hand-off and output handshake.
   always_comb begin
      idx_d       = idx_q;
      fill_d      = fill_q;
      out_d       = out_q;
      vec_valid_d = vec_valid_q;
      pending_d   = pending_q;
      frame_err_d = frame_err_q;

      accept_s    = s_valid && !pending_q;
      at_end_s    = (idx_q == LAST_IDX);
      complete_s  = accept_s && at_end_s;
      slot_free_s = !vec_valid_q || vec_ready;

      // Fill buffer including the element arriving this cycle, so a completing vector is forwarded whole.
      fill_w_s         = fill_q;
      fill_w_s[idx_q]  = s_data;

      if (accept_s) begin
         fill_d = fill_w_s;
         idx_d  = at_end_s ? '0 : (idx_q + CNT_W'(1));
      end else begin
         fill_d = fill_q;
      end

`ifdef NPU_VEC_LOADER_LAST_CHECK_EN
      if (accept_s && s_last && !at_end_s) begin
         idx_d       = '0;
         frame_err_d = 1'b1;
      end else if (complete_s && !s_last) begin
         frame_err_d = 1'b1;
      end else begin
         frame_err_d = frame_err_q;
      end
`else
      frame_err_d = 1'b0;
`endif

      if (pending_q) begin
         if (slot_free_s) begin
            out_d       = fill_q;
            vec_valid_d = 1'b1;
            pending_d   = 1'b0;
         end else begin
            pending_d   = 1'b1;
         end
      end else if (complete_s) begin
         if (slot_free_s) begin
            out_d       = fill_w_s;
            vec_valid_d = 1'b1;
         end else begin
            pending_d   = 1'b1;
         end
      end else if (vec_valid_q && vec_ready) begin
         vec_valid_d = 1'b0;
      end else begin
         vec_valid_d = vec_valid_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q       <= '0;
         fill_q      <= '0;
         out_q       <= '0;
         vec_valid_q <= 1'b0;
         pending_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         idx_q       <= idx_d;
         fill_q      <= fill_d;
         out_q       <= out_d;
         vec_valid_q <= vec_valid_d;
         pending_q   <= pending_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign s_ready   = !pending_q;
   assign vec_out   = out_q;
   assign vec_valid = vec_valid_q;

`ifdef NPU_VEC_LOADER_LAST_CHECK_EN
   assign frame_err = frame_err_q;
`else
   logic unused_last_s;
   assign unused_last_s = s_last ^ frame_err_q;
   assign frame_err     = 1'b0;
`endif

endmodule

// File: tb/tb_npu_vec_loader.sv
// Directed self-checking bench for npu_vec_loader with IN_N=4, DATA_WIDTH=8.
module tb_npu_vec_loader;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            s_valid;
   logic            s_ready;
   logic [7:0]      s_data;
   logic            s_last;
   logic [3:0][7:0] vec_out;
   logic            vec_valid;
   logic            vec_ready;
   logic            frame_err;

   int checks   = 0;
   int failures = 0;

`ifdef NPU_VEC_LOADER_LAST_CHECK_EN
   localparam bit LAST_EN = 1'b1;
`else
   localparam bit LAST_EN = 1'b0;
`endif

   npu_vec_loader #(.IN_N(4), .DATA_WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .vec_out   (vec_out),
      .vec_valid (vec_valid),
      .vec_ready (vec_ready),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0][7:0] mk(input logic [7:0] e0, input logic [7:0] e1,
                                          input logic [7:0] e2, input logic [7:0] e3);
      logic [3:0][7:0] r;
      r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d, input logic l);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      tick();
   endtask

   task automatic idle();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; vec_ready = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      checks++; if (vec_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", vec_valid); end
      checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", frame_err); end
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", s_ready); end
      tick(); tick(); tick();
      checks++; if (vec_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", vec_valid); end
   endtask

   task automatic test_single();
      logic [3:0][7:0] exp_v;
      exp_v = mk(8'h01, 8'hFE, 8'h03, 8'hFC);
      vec_ready = 1'b1;
      push(8'h01, 1'b0); push(8'hFE, 1'b0); push(8'h03, 1'b0);
      checks++; if (vec_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", vec_valid); end
      push(8'hFC, 1'b1);
      idle();
      checks++; if (vec_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", vec_valid); end
      checks++; if (vec_out !== exp_v) begin failures++; $display("FAIL single_data got=%h exp=%h", vec_out, exp_v); end
      tick();
      checks++; if (vec_valid !== 1'b0) begin failures++; $display("FAIL single_pulse got=%b exp=0", vec_valid); end
   endtask

   task automatic test_backpressure();
      logic [3:0][7:0] a, b, c;
      a = mk(8'd1, 8'd2, 8'd3, 8'd4);
      b = mk(8'd5, 8'd6, 8'd7, 8'd8);
      c = mk(8'd13, 8'd14, 8'd15, 8'd16);
      vec_ready = 1'b0;
      push(8'd1, 1'b0); push(8'd2, 1'b0); push(8'd3, 1'b0); push(8'd4, 1'b1);
      push(8'd5, 1'b0); push(8'd6, 1'b0); push(8'd7, 1'b0); push(8'd8, 1'b1);
      checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_stall got=%b exp=0", s_ready); end
      checks++; if (vec_out !== a) begin failures++; $display("FAIL bp_hold_a got=%h exp=%h", vec_out, a); end
      push(8'd13, 1'b0);
      checks++; if (vec_out !== a || vec_valid !== 1'b1) begin failures++; $display("FAIL bp_stable got=%h/%b exp=%h/1", vec_out, vec_valid, a); end
      vec_ready = 1'b1;
      tick();
      vec_ready = 1'b0;
      checks++; if (vec_out !== b || vec_valid !== 1'b1) begin failures++; $display("FAIL bp_b got=%h/%b exp=%h/1", vec_out, vec_valid, b); end
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back got=%b exp=1", s_ready); end
      push(8'd13, 1'b0); push(8'd14, 1'b0); push(8'd15, 1'b0); push(8'd16, 1'b1);
      idle();
      vec_ready = 1'b1;
      tick();
      checks++; if (vec_out !== c || vec_valid !== 1'b1) begin failures++; $display("FAIL bp_c got=%h/%b exp=%h/1", vec_out, vec_valid, c); end
      tick();
      checks++; if (vec_valid !== 1'b0 || s_ready !== 1'b1) begin failures++; $display("FAIL bp_drain got=%b/%b exp=0/1", vec_valid, s_ready); end
   endtask

   task automatic test_simultaneous();
      logic [3:0][7:0] a, b;
      a = mk(8'h11, 8'h22, 8'h33, 8'h44);
      b = mk(8'h80, 8'h7F, 8'hAA, 8'h55);
      vec_ready = 1'b0;
      push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0); push(8'h44, 1'b1);
      checks++; if (vec_out !== a) begin failures++; $display("FAIL simul_a got=%h exp=%h", vec_out, a); end
      push(8'h80, 1'b0); push(8'h7F, 1'b0); push(8'hAA, 1'b0);
      vec_ready = 1'b1;
      push(8'h55, 1'b1);
      idle();
      vec_ready = 1'b0;
      checks++; if (vec_valid !== 1'b1 || vec_out !== b) begin failures++; $display("FAIL simul_b got=%h/%b exp=%h/1", vec_out, vec_valid, b); end
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL simul_nostall got=%b exp=1", s_ready); end
      vec_ready = 1'b1;
      tick();
      checks++; if (vec_valid !== 1'b0) begin failures++; $display("FAIL simul_drain got=%b exp=0", vec_valid); end
   endtask

   task automatic test_back_to_back();
      logic [3:0][7:0] v0, v1;
      v0 = mk(8'd40, 8'd41, 8'd42, 8'd43);
      v1 = mk(8'hF0, 8'hF1, 8'hF2, 8'hF3);
      vec_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i < 4) push(v0[i], (i == 3));
         else       push(v1[i-4], (i == 7));
         checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, s_ready); end
         checks++; if (vec_valid !== (i == 3 || i == 7)) begin failures++; $display("FAIL b2b_valid[%0d] got=%b exp=%b", i, vec_valid, (i == 3 || i == 7)); end
      end
      idle();
      checks++; if (vec_out !== v1) begin failures++; $display("FAIL b2b_data got=%h exp=%h", vec_out, v1); end
      tick();
   endtask

   task automatic test_reset_mid();
      logic [3:0][7:0] exp_v;
      exp_v = mk(8'd9, 8'd10, 8'd11, 8'd12);
      vec_ready = 1'b1;
      push(8'd7, 1'b0); push(8'd8, 1'b0);
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      checks++; if (vec_valid !== 1'b0) begin failures++; $display("FAIL rmid_novalid got=%b exp=0", vec_valid); end
      push(8'd9, 1'b0); push(8'd10, 1'b0); push(8'd11, 1'b0);
      checks++; if (vec_valid !== 1'b0) begin failures++; $display("FAIL rmid_stale got=%b exp=0", vec_valid); end
      push(8'd12, 1'b1);
      idle();
      checks++; if (vec_valid !== 1'b1 || vec_out !== exp_v) begin failures++; $display("FAIL rmid_data got=%h/%b exp=%h/1", vec_out, vec_valid, exp_v); end
      tick();
   endtask

   task automatic test_framing();
      logic [3:0][7:0] exp_v;
      vec_ready = 1'b1;
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      push(8'd21, 1'b0); push(8'd22, 1'b1); push(8'd23, 1'b0); push(8'd24, 1'b0);
      exp_v = mk(8'd21, 8'd22, 8'd23, 8'd24);
      checks++; if (frame_err !== LAST_EN) begin failures++; $display("FAIL frame_err got=%b exp=%b", frame_err, LAST_EN); end
      checks++; if (vec_valid !== !LAST_EN) begin failures++; $display("FAIL frame_valid4 got=%b exp=%b", vec_valid, !LAST_EN); end
      if (!LAST_EN) begin
         checks++; if (vec_out !== exp_v) begin failures++; $display("FAIL frame_span got=%h exp=%h", vec_out, exp_v); end
      end
      push(8'd25, 1'b0); push(8'd26, 1'b1);
      idle();
      exp_v = mk(8'd23, 8'd24, 8'd25, 8'd26);
      checks++; if (vec_valid !== LAST_EN) begin failures++; $display("FAIL frame_valid6 got=%b exp=%b", vec_valid, LAST_EN); end
      if (LAST_EN) begin
         checks++; if (vec_out !== exp_v) begin failures++; $display("FAIL frame_realign got=%h exp=%h", vec_out, exp_v); end
      end
      tick();
      checks++; if (frame_err !== LAST_EN) begin failures++; $display("FAIL frame_sticky got=%b exp=%b", frame_err, LAST_EN); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid();
      test_framing();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
